// File: rtl/mdu.sv
// Iterative MIPS32 multiply/divide unit owning HI/LO: 32-step shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier instead.
module mdu (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] orig_q, orig_d;
    logic        div_q, div_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        op_signed;
    logic [31:0] abs1, abs2;
    logic [32:0] mul_sum;
    logic [32:0] div_rem;
    logic [33:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    assign op_signed = ~op[0];
    assign abs1      = (op_signed && src1[31]) ? (~src1 + 32'd1) : src1;
    assign abs2      = (op_signed && src2[31]) ? (~src2 + 32'd1) : src2;

    // Multiplier sits in acc[31:0] and shifts out as the product shifts in from the top.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);

    // Dividend bits shift out of acc[31:0] into the partial remainder; quotient bits shift in.
    assign div_rem   = {acc_q[63:32], acc_q[31]};
    assign div_diff  = {1'b0, div_rem} - {2'b00, a_q};

    assign prod_fix  = neg_q  ? (~acc_q + 64'd1) : acc_q;
    assign quot_fix  = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix   = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

`ifdef MDU_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, abs1} * {32'd0, abs2};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        orig_d  = orig_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            div_d   = op[1];
                            neg_d   = op_signed & (src1[31] ^ src2[31]);
                            rneg_d  = op_signed & src1[31];
                            dz_d    = (src2 == 32'd0);
                            orig_d  = src1;
                            a_d     = abs2;
                            acc_d   = {32'd0, abs1};
                            cnt_d   = 5'd0;
                            state_d = S_CALC;
`ifdef MDU_FAST_MUL_EN
                            if (!op[1]) begin
                                acc_d   = fast_prod;
                                state_d = S_FIX;
                            end
`endif
                        end else if (op[1:0] == 2'b00) begin
                            hi_d = src1;
                        end else if (op[1:0] == 2'b01) begin
                            lo_d = src1;
                        end
                    end
                end
                S_CALC: begin
                    if (div_q) begin
                        acc_d = div_diff[33] ? {div_rem[31:0], acc_q[30:0], 1'b0}
                                             : {div_diff[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        cnt_d   = 5'd0;
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (div_q) begin
                        if (dz_q) begin
                            lo_d = 32'hFFFF_FFFF;
                            hi_d = orig_q;
                        end else begin
                            lo_d = quot_fix;
                            hi_d = rem_fix;
                        end
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            a_q     <= 32'd0;
            orig_q  <= 32'd0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            orig_q  <= orig_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: expected {hi,lo} queued at issue, popped and compared on each done pulse.
module tb_mdu;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_CYC = 1;
    localparam logic [2:0] RST_OP = OP_DIVU;
`else
    localparam int MUL_CYC = 33;
    localparam logic [2:0] RST_OP = OP_MULT;
`endif
    localparam int DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic        prev_done = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    mdu dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", {63'd0, done}, 64'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("hi_lo", {hi, lo}, exp_v);
                end
                if (prev_done) check("done_pulse", {63'd0, prev_done}, 64'd0);
            end
            prev_done = done;
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input int exp_busy);
        int n;
        @(negedge clk);
        exp_q.push_back(e);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, exp_busy);
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; op = o; src1 = a;
        @(negedge clk);
        start = 1'b0;
        check("mt_busy", {63'd0, busy}, 64'd0);
        if (o == OP_MTHI) check("mthi", hi, a);
        else              check("mtlo", lo, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        resetn = 1'b1;

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA, MUL_CYC);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_CYC);
        run_op(OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'h0000_0000_0000_001E, MUL_CYC);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, DIV_CYC);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_CYC);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DIV_CYC);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, DIV_CYC);
        run_op(OP_DIVU,  32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, DIV_CYC);
        run_op(OP_DIVU,  32'd9,         32'd4,         64'h0000_0001_0000_0002, DIV_CYC);
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, DIV_CYC);

        move_to(OP_MTLO, 32'h1234_5678);
        move_to(OP_MTHI, 32'hAAAA_5555);

        // flush beats start in the same idle cycle
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; src1 = 32'h0000_0001; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_hi", hi, 32'hAAAA_5555);
        check("flush_start_busy", {63'd0, busy}, 64'd0);

        // reserved op does nothing
        @(negedge clk);
        start = 1'b1; op = 3'b110; src1 = 32'h5555_0000; src2 = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("reserved_busy", {63'd0, busy}, 64'd0);
        check("reserved_hilo", {hi, lo}, 64'hAAAA_5555_1234_5678);

        // DIVU 9/4 flushed at counter 10, with an ignored start during busy
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src1 = 32'd9; src2 = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = OP_MULT; src1 = 32'd5; src2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("busy_before_flush", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("busy_after_flush", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_idle", {63'd0, busy}, 64'd0);
        check("flush_hilo", {hi, lo}, 64'hAAAA_5555_1234_5678);

        // asynchronous reset mid-calculation
        @(negedge clk);
        start = 1'b1; op = RST_OP; src1 = 32'd3; src2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(OP_MULT, 32'd5, 32'd6, 64'h0000_0000_0000_001E, MUL_CYC);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the MIPS32 pipeline, executing MULT, MULTU, DIV, DIVU, MTHI and MTLO and owning the architectural HI/LO registers. It takes the operands the execute stage would otherwise send to the combinational ALU and runs them through an iterative 32-step datapath. It reports `busy` so the hazard unit can stall dependent MFHI/MFLO and further MDU ops, and pulses `done` when results land.

## Interface

Parameters: none.

Ports:
- `clk` input 1 — the single clock; all state updates on the rising edge.
- `resetn` input 1 — reset, asynchronous, active-low.
- `start` input 1 — issue an op this cycle; sampled only when `busy`=0.
- `op` input 3 — 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no effect).
- `src1` input 32 — rs: multiplicand, dividend, or MTHI/MTLO data.
- `src2` input 32 — rt: multiplier or divisor.
- `flush` input 1 — abort any in-flight op; has priority over `start`.
- `busy` output 1 — state ≠ IDLE.
- `done` output 1 — one-cycle pulse when HI/LO are written by a mult/div.
- `hi` output 32 — HI register.
- `lo` output 32 — LO register.

## Operation

- States: IDLE, CALC, FIX.
- IDLE, `start`=1, `flush`=0:
  - mult/div op: latch |src1|, |src2| (absolute values for signed ops, raw values for unsigned), the result signs and the op; counter←0; go to CALC.
  - MTHI/MTLO: write `hi`/`lo` ← src1 at this edge; stay IDLE; no `done`.
  - Reserved op: ignored.
- CALC: one iteration per cycle, 32 cycles, counter 0..31. On counter=31, go to FIX.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring; 32-bit partial remainder with a 33-bit subtract.
- FIX: apply signs and write HI/LO; `done`=1; go to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient sign = sign1^sign2; remainder sign = dividend sign.
- Result mapping: multiply gives hi = product[63:32], lo = product[31:0]. Divide gives lo = quotient, hi = remainder.
- Divide by zero, both signednesses: lo=0xFFFFFFFF, hi=src1 (original value, unmodified).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- `start` while `busy`=1: ignored; the hazard unit must hold the instruction.
- `flush`=1 in any state: next state IDLE, counter cleared. HI/LO unchanged, no `done`.
- `flush` and `start` in the same IDLE cycle: start dropped, including MTHI/MTLO.

## Timing

- Reset (asynchronous, `resetn`=0): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0. Outputs take these values immediately on reset assertion.
- Mult/div accepted at edge E0:
  - `busy`=1 from after E0 through the cycle ending at E33.
  - `done`=1 and new `hi`/`lo` visible after E33 for exactly one cycle.
  - `busy`=0 in that same cycle, so a new op may start at E34.
- MTHI/MTLO accepted at E0: value visible after E0; `busy` never asserts.
- `done` never asserts in two consecutive cycles.
- `busy`, `done`, `hi` and `lo` are all registered or state-decoded; none depend combinationally on inputs.
- `resetn` asserted mid-op: op aborted; all outputs return to their reset values asynchronously.

## Configuration

- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU compute the full 64-bit product with a single-cycle multiplier in IDLE and go directly to FIX.
  - Accept at E0, `busy`=1 for one cycle, `done` and HI/LO after E1.
  - DIV/DIVU timing is unchanged.
- `MDU_FAST_MUL_EN` undefined: all mult/div use the 32-cycle iterative path. No multiplier is inferred.

## Test plan

- Reset, then MULT src1=0xFFFFFFFE, src2=3 → `busy` high 33 cycles; `done` after E33 with hi=0xFFFFFFFF, lo=0xFFFFFFFA. With `MDU_FAST_MUL_EN`: same values after E1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=0x00000064. Then MTLO 0x12345678 → lo=0x12345678 next cycle, `busy` stays 0, no `done`.
- MTHI 0xAAAA5555, then DIVU 9/4 with `flush`=1 at CALC counter=10 → `busy`=0 next cycle, no `done`, hi=0xAAAA5555 retained. A `start` issued during the busy window is ignored.
- `resetn` pulsed low mid-CALC of MULT → `busy`, `done`, `hi`, `lo` go to 0 without a clock edge. The next MULT 5×6 gives hi=0, lo=30 after 33 edges.
